// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing one memory-mapped IO port among NUM_REQ requesters.
// Each access runs IDLE -> ACCESS -> RESP; the IO block acts on the ACCESS negedge.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   req/req_we          per-requester level request and write(1)/read(0) select
//   req_addr/req_wdata  packed per-requester address and write data (slot i at i*W)
//   gnt                 one-hot grant, high during ACCESS and RESP
//   ack                 one-hot completion pulse, high during RESP only
//   rdata               read data of the last completed read, valid with ack
//   busy                high whenever the sequencer is not idle
//   io_cs/io_we         chip select and write enable to the IO block
//   io_addr/io_wdata    address and write data to the IO block (hold in IDLE)
//   io_rdata            read data from the IO block
module io_bus_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic                      io_cs,
    output logic                      io_we,
    output logic [ADDR_W-1:0]         io_addr,
    output logic [DATA_W-1:0]         io_wdata,
    input  logic [DATA_W-1:0]         io_rdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Pointer resets to the last slot so that slot 0 is scanned first.
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 cs_q, cs_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;

    logic                 pick_valid;
    logic [PTR_W-1:0]     pick_idx;
    logic [PTR_W-1:0]     cand;
    logic [NUM_REQ-1:0]   pick_onehot;

    // Scan ptr+1, ptr+2, ... (mod NUM_REQ); first high request wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        cand       = ptr_q;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = PTR_W'((int'(ptr_q) + off) % NUM_REQ);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        ack_d   = ack_q;
        rdata_d = rdata_q;
        cs_d    = cs_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ACCESS;
                    ptr_d   = pick_idx;
                    gnt_d   = pick_onehot;
                    cs_d    = 1'b1;
                    we_d    = req_we[pick_idx];
                    addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata[pick_idx*DATA_W +: DATA_W];
                end
            end
            ACCESS: begin
                // IO block acted on the negedge; capture only for reads.
                state_d = RESP;
                cs_d    = 1'b0;
                we_d    = 1'b0;
                ack_d   = gnt_q;
                if (!we_q) begin
                    rdata_d = io_rdata;
                end
            end
            RESP: begin
                state_d = IDLE;
                ack_d   = '0;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                ack_d   = '0;
                gnt_d   = '0;
                cs_d    = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RST;
            gnt_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign rdata    = rdata_q;
    assign busy     = (state_q != IDLE);
    assign io_cs    = cs_q;
    assign io_we    = we_q;
    assign io_addr  = addr_q;
    assign io_wdata = wdata_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter with a scoreboard of expected acks.
// Expected completions are queued at request time and popped on ack.
module tb_io_bus_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    logic                      clock;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;
    logic                      io_cs;
    logic                      io_we;
    logic [ADDR_W-1:0]         io_addr;
    logic [DATA_W-1:0]         io_wdata;
    logic [DATA_W-1:0]         io_rdata;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    io_bus_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .gnt      (gnt),
        .ack      (ack),
        .rdata    (rdata),
        .busy     (busy),
        .io_cs    (io_cs),
        .io_we    (io_we),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic we,
                            input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        req_we[i] = we;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic sb_pop(input string tag);
        exp_t e;
        check({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_ack"}, 32'(ack), 32'(1 << e.idx));
            check({tag, "_rdata"}, rdata, e.data);
        end
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        io_rdata  = '0;

        // T1: reset state
        repeat (2) tick();
        check("t1_gnt", 32'(gnt), 32'd0);
        check("t1_ack", 32'(ack), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_cs", 32'(io_cs), 32'd0);
        check("t1_rdata", rdata, 32'd0);
        #3 reset = 1'b0;
        tick();

        // T2: read from requester 0
        set_slot(0, 1'b0, 5'd0, 32'h0);
        req      = 2'b01;
        io_rdata = 32'h0000_000A;
        sb.push_back('{0, 32'h0000_000A});
        tick();
        check("t2_gnt", 32'(gnt), 32'd1);
        check("t2_cs", 32'(io_cs), 32'd1);
        check("t2_we", 32'(io_we), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_ack_early", 32'(ack), 32'd0);
        check("t2_addr", 32'(io_addr), 32'd0);
        tick();
        sb_pop("t2");
        check("t2_cs_off", 32'(io_cs), 32'd0);
        check("t2_gnt_resp", 32'(gnt), 32'd1);
        check("t2_busy_resp", 32'(busy), 32'd1);
        req = 2'b00;
        tick();
        check("t2_ack_off", 32'(ack), 32'd0);
        check("t2_gnt_off", 32'(gnt), 32'd0);
        check("t2_busy_off", 32'(busy), 32'd0);

        // T3: write from requester 1, rdata must not change
        set_slot(1, 1'b1, 5'd0, 32'h5);
        req      = 2'b10;
        io_rdata = 32'hDEAD_BEEF;
        sb.push_back('{1, 32'h0000_000A});
        tick();
        check("t3_gnt", 32'(gnt), 32'd2);
        check("t3_cs", 32'(io_cs), 32'd1);
        check("t3_we", 32'(io_we), 32'd1);
        check("t3_wdata", io_wdata, 32'h5);
        tick();
        sb_pop("t3");
        check("t3_we_off", 32'(io_we), 32'd0);
        check("t3_cs_off", 32'(io_cs), 32'd0);
        req = 2'b00;
        tick();
        check("t3_gnt_off", 32'(gnt), 32'd0);
        check("t3_wdata_hold", io_wdata, 32'h5);

        // T4: contention, alternating grants three cycles apart
        set_slot(0, 1'b0, 5'd3, 32'h11);
        set_slot(1, 1'b0, 5'd7, 32'h22);
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            io_rdata = 32'h100 + 32'(g);
            sb.push_back('{g % 2, 32'h100 + 32'(g)});
            tick();
            check("t4_gnt", 32'(gnt), 32'(1 << (g % 2)));
            check("t4_cs", 32'(io_cs), 32'd1);
            check("t4_addr", 32'(io_addr), (g % 2 == 1) ? 32'd7 : 32'd3);
            tick();
            sb_pop("t4");
            if (g == 3) req = 2'b00;
            tick();
            check("t4_gnt_gap", 32'(gnt), 32'd0);
            check("t4_busy_gap", 32'(busy), 32'd0);
        end

        // T5: reset during ACCESS abandons the access
        req = 2'b11;
        tick();
        check("t5_gnt", 32'(gnt), 32'd1);
        check("t5_cs", 32'(io_cs), 32'd1);
        #3 reset = 1'b1;
        #1;
        check("t5_cs_rst", 32'(io_cs), 32'd0);
        check("t5_we_rst", 32'(io_we), 32'd0);
        check("t5_gnt_rst", 32'(gnt), 32'd0);
        check("t5_ack_rst", 32'(ack), 32'd0);
        check("t5_busy_rst", 32'(busy), 32'd0);
        check("t5_rdata_rst", rdata, 32'd0);
        check("t5_addr_rst", 32'(io_addr), 32'd0);
        check("t5_wdata_rst", io_wdata, 32'd0);
        tick();
        check("t5_no_ack", 32'(ack), 32'd0);
        #3 reset = 1'b0;
        io_rdata = 32'h55;
        sb.push_back('{0, 32'h55});
        tick();
        check("t5_regrant", 32'(gnt), 32'd1);
        tick();
        sb_pop("t5");
        req = 2'b00;
        tick();
        check("t5_gnt_off", 32'(gnt), 32'd0);

        // T6: request dropped during ACCESS still completes once
        set_slot(1, 1'b0, 5'd9, 32'h0);
        req      = 2'b10;
        io_rdata = 32'h77;
        sb.push_back('{1, 32'h77});
        tick();
        check("t6_gnt", 32'(gnt), 32'd2);
        req = 2'b00;
        tick();
        sb_pop("t6");
        tick();
        check("t6_ack_off", 32'(ack), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t6_no_regrant", 32'(gnt), 32'd0);
            check("t6_idle", 32'(busy), 32'd0);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
